bus_master: RTL and testbench
=============================

BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning cycles after the ISSUE cycle before rdata_cpu is sampled; legal range 0..3.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports cmd_valid  input  1, cmd_ready  output  1, forming the command handshake.
REQ-006 SHALL have ports cmd_write  input  1 (1 = write), cmd_addr  input  32, cmd_wdata  input  32, and cmd_be  input  4 (byte enables).
REQ-007 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, forming the response handshake.
REQ-008 SHALL have ports rsp_rdata  output  32 (read data) and rsp_write  output  1 (echo of the command type).
REQ-009 SHALL have ports addr_cpu  output  32, wdata_cpu  output  32, and we_cpu  output  4, driving the arbiter's CPU side.
REQ-010 SHALL have port rdata_cpu  input  32, read data returned by the arbiter.
REQ-011 SHALL have port cmd_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 SHALL accept a command into the FIFO on each rising edge where cmd_valid=1 and cmd_ready=1.
REQ-013 SHALL drive cmd_ready = (FIFO not full) combinationally; a full FIFO blocks the push even in a cycle where a pop occurs; there is no empty-FIFO bypass.
REQ-014 SHALL implement an FSM with states IDLE, ISSUE, WAIT, and RESP.
REQ-015 SHALL, in IDLE with the FIFO non-empty, pop the head into the issue register and enter ISSUE; in IDLE with the FIFO empty, remain in IDLE.
REQ-016 SHALL, in ISSUE, drive addr_cpu = {cmd_addr[31:2],2'b00} and wdata_cpu = cmd_wdata for one cycle, with we_cpu = cmd_be on a write and 4'b0000 on a read.
REQ-017 SHALL, for a write, go from ISSUE to RESP with rsp_rdata=0 and rsp_write=1.
REQ-018 SHALL, for a read with RD_LAT=0, sample rdata_cpu at the edge ending ISSUE and enter RESP.
REQ-019 SHALL, for a read with RD_LAT>0, enter WAIT for exactly RD_LAT cycles, then sample rdata_cpu at the edge ending the last WAIT cycle and enter RESP.
REQ-020 SHALL, in WAIT, hold addr_cpu stable with we_cpu=0.
REQ-021 SHALL, in RESP, assert rsp_valid and hold rsp_rdata and rsp_write stable until the edge where rsp_ready=1.
REQ-022 SHALL, on that RESP handshake edge, pop the head and enter ISSUE if the FIFO is non-empty, otherwise enter IDLE.
REQ-023 SHALL keep we_cpu=0 outside ISSUE, and keep addr_cpu and wdata_cpu holding their last driven values outside ISSUE and WAIT.
REQ-024 SHALL have at most one command in flight; responses are returned in command order.
REQ-025 SHALL keep FIFO pointers wrapping modulo FIFO_DEPTH, and SHALL keep cmd_count correct under a simultaneous push and pop (unchanged).
REQ-026 SHALL make cmd_count exclude the in-flight command.

Reset
REQ-027 SHALL, while reset=0, immediately force state=IDLE, the FIFO empty, cmd_count=0, rsp_valid=0, rsp_rdata=0, rsp_write=0, addr_cpu=0, wdata_cpu=0, and we_cpu=0.
REQ-028 SHALL drive cmd_ready=1 after reset release.
REQ-029 SHALL discard any in-flight command and all queued commands when reset is asserted mid-operation; no response is produced for them after release.

Verification
REQ-030 SHALL cover: with RD_LAT=1, a write to addr 0x84, wdata 0x1, be 0xF -> in the 2nd cycle after the accept edge, we_cpu=0xF, addr_cpu=0x84, wdata_cpu=0x1 for exactly one cycle; the next cycle, rsp_valid=1, rsp_write=1, rsp_rdata=0.
REQ-031 SHALL cover: with RD_LAT=1, a read of 0x84 with the peripheral model returning 0x3 -> we_cpu stays 0 throughout, and rsp_rdata=0x3 with rsp_valid in the cycle after the WAIT cycle.
REQ-032 SHALL cover: with rsp_ready=0 and cmd_valid held high -> 5 commands accepted (1 in flight, 4 queued), then cmd_ready=0 and cmd_count=4; raising rsp_ready drains the FIFO in order.
REQ-033 SHALL cover: rsp_ready held 0 for 3 cycles during RESP -> rsp_valid, rsp_rdata, and rsp_write remain stable, and the next command does not issue until the handshake.
REQ-034 SHALL cover: reset=0 pulsed during WAIT of a read to 0x88 -> all outputs 0 immediately; after release, cmd_ready=1, cmd_count=0, and no rsp_valid appears.
REQ-035 SHALL cover: RD_LAT=0 and RD_LAT=3 builds, read 0x8C returning 0x9 -> rsp_valid appears 1 cycle and 4 cycles after ISSUE respectively, with rsp_rdata=0x9.

Source files
------------

// File: rtl/bus_master.sv
// bus_master: queues bus commands in a small FIFO and replays them one at a
// time on the arbiter's CPU-side port, returning one response per command in
// command order.
//
// Ports
//   clk, reset                 clock and asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready = FIFO not full)
//   cmd_write/addr/wdata/be    command payload
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/rsp_write        response payload (read data, command type echo)
//   addr_cpu/wdata_cpu/we_cpu  arbiter CPU-side request
//   rdata_cpu                  arbiter read data
//   cmd_count                  FIFO occupancy, excluding the in-flight command
//
// Parameters
//   RD_LAT      cycles after ISSUE before rdata_cpu is sampled (0..3)
//   FIFO_DEPTH  command FIFO entries (power of two, >= 2)

module bus_master #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [31:0]                 cmd_addr,
    input  logic [31:0]                 cmd_wdata,
    input  logic [3:0]                  cmd_be,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [31:0]                 rsp_rdata,
    output logic                        rsp_write,
    output logic [31:0]                 addr_cpu,
    output logic [31:0]                 wdata_cpu,
    output logic [3:0]                  we_cpu,
    input  logic [31:0]                 rdata_cpu,
    output logic [$clog2(FIFO_DEPTH):0] cmd_count
);

    // state | meaning
    // IDLE  | no command in flight, waiting for the FIFO to become non-empty
    // ISSUE | one-cycle request on the CPU port (write strobes only here)
    // WAIT  | read latency countdown, address held, we_cpu = 0
    // RESP  | response presented, held until rsp_ready

    localparam int            PW         = $clog2(FIFO_DEPTH);
    localparam int            EW         = 1 + 4 + 30 + 32;
    localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]    WAIT_LOAD  = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // FIFO entry layout: {write, be, addr[31:2], wdata}
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop, fifo_empty;
    logic [EW-1:0] head;

    logic          iss_write;
    logic [3:0]    iss_be;
    logic [29:0]   iss_addr;
    logic [31:0]   iss_wdata;

    logic [1:0]    wait_cnt;
    logic          load_wait;
    logic          capture;

    // Word-aligned addressing only; the byte offset is intentionally dropped.
    logic          addr_lsb_unused;
    assign addr_lsb_unused = ^cmd_addr[1:0];

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != FULL_COUNT);
    assign push       = cmd_valid & cmd_ready;
    assign head       = fifo_mem[rd_ptr];
    assign cmd_count  = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_write, cmd_be, cmd_addr[31:2], cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_wait = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (iss_write || RD_LAT == 0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    load_wait = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            iss_write <= 1'b0;
            iss_be    <= '0;
            iss_addr  <= '0;
            iss_wdata <= '0;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                {iss_write, iss_be, iss_addr, iss_wdata} <= head;
            end
            if (load_wait) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (capture) begin
                rsp_write <= iss_write;
                rsp_rdata <= iss_write ? 32'h0 : rdata_cpu;
            end
        end
    end

    // The issue register doubles as the CPU-side address/data hold register,
    // so addr_cpu/wdata_cpu keep their last values after the command retires.
    assign addr_cpu  = {iss_addr, 2'b00};
    assign wdata_cpu = iss_wdata;
    assign we_cpu    = (state == ISSUE && iss_write) ? iss_be : 4'b0000;
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_bus_master.sv
module tb_bus_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_ready;

    logic        cmd_ready,   z_cmd_ready,   t_cmd_ready;
    logic        rsp_valid,   z_rsp_valid,   t_rsp_valid;
    logic [31:0] rsp_rdata,   z_rsp_rdata,   t_rsp_rdata;
    logic        rsp_write,   z_rsp_write,   t_rsp_write;
    logic [31:0] addr_cpu,    z_addr_cpu,    t_addr_cpu;
    logic [31:0] wdata_cpu,   z_wdata_cpu,   t_wdata_cpu;
    logic [3:0]  we_cpu,      z_we_cpu,      t_we_cpu;
    logic [31:0] rdata_cpu,   z_rdata_cpu,   t_rdata_cpu;
    logic [2:0]  cmd_count,   z_cmd_count,   t_cmd_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Peripheral model: fixed values for the directed addresses, otherwise
    // address + 0x1000.
    function automatic logic [31:0] periph(input logic [31:0] a);
        if (a == 32'h84) return 32'h3;
        if (a == 32'h8C) return 32'h9;
        return a + 32'h1000;
    endfunction

    assign rdata_cpu   = periph(addr_cpu);
    assign z_rdata_cpu = periph(z_addr_cpu);
    assign t_rdata_cpu = periph(t_addr_cpu);

    bus_master #(.RD_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_write(rsp_write),
        .addr_cpu(addr_cpu), .wdata_cpu(wdata_cpu), .we_cpu(we_cpu),
        .rdata_cpu(rdata_cpu), .cmd_count(cmd_count)
    );

    bus_master #(.RD_LAT(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(z_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_write(z_rsp_write),
        .addr_cpu(z_addr_cpu), .wdata_cpu(z_wdata_cpu), .we_cpu(z_we_cpu),
        .rdata_cpu(z_rdata_cpu), .cmd_count(z_cmd_count)
    );

    bus_master #(.RD_LAT(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(t_rsp_rdata), .rsp_write(t_rsp_write),
        .addr_cpu(t_addr_cpu), .wdata_cpu(t_wdata_cpu), .we_cpu(t_we_cpu),
        .rdata_cpu(t_rdata_cpu), .cmd_count(t_cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        reset     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_be    = '0;
        rsp_ready = 1'b1;
        reset     = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({rsp_valid, rsp_rdata, rsp_write, addr_cpu, wdata_cpu, we_cpu, cmd_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b rdata=%h write=%b addr=%h wdata=%h we=%h count=%0d expected all zero",
                     rsp_valid, rsp_rdata, rsp_write, addr_cpu, wdata_cpu, we_cpu, cmd_count);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || cmd_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b count=%0d expected ready=1 count=0", cmd_ready, cmd_count);
        end
    endtask

    task automatic test_write();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h84;
        cmd_wdata = 32'h1;
        cmd_be    = 4'hF;
        tick();                       // accept edge
        cmd_valid = 1'b0;
        n_checks++;
        if (we_cpu !== 4'h0 || cmd_count !== 3'd1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_queued: got we=%h count=%0d valid=%b expected we=0 count=1 valid=0", we_cpu, cmd_count, rsp_valid);
        end
        tick();                       // ISSUE
        n_checks++;
        if (we_cpu !== 4'hF || addr_cpu !== 32'h84 || wdata_cpu !== 32'h1 || cmd_count !== 3'd0) begin
            n_fail++;
            $display("FAIL write_issue: got we=%h addr=%h wdata=%h count=%0d expected we=f addr=84 wdata=1 count=0",
                     we_cpu, addr_cpu, wdata_cpu, cmd_count);
        end
        tick();                       // RESP
        n_checks++;
        if (we_cpu !== 4'h0 || rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL write_resp: got we=%h valid=%b write=%b rdata=%h expected we=0 valid=1 write=1 rdata=0",
                     we_cpu, rsp_valid, rsp_write, rsp_rdata);
        end
        tick();                       // back to IDLE
        n_checks++;
        if (rsp_valid !== 1'b0 || addr_cpu !== 32'h84 || wdata_cpu !== 32'h1 || we_cpu !== 4'h0) begin
            n_fail++;
            $display("FAIL write_idle_hold: got valid=%b addr=%h wdata=%h we=%h expected valid=0 addr=84 wdata=1 we=0",
                     rsp_valid, addr_cpu, wdata_cpu, we_cpu);
        end
    endtask

    task automatic test_read();
        logic we_seen;
        we_seen   = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h85;           // byte offset must be dropped on the CPU side
        cmd_wdata = 32'hDEAD_BEEF;
        cmd_be    = 4'hF;
        tick();
        cmd_valid = 1'b0;
        we_seen   = we_seen | (we_cpu != 4'h0);
        tick();                       // ISSUE
        we_seen   = we_seen | (we_cpu != 4'h0);
        n_checks++;
        if (addr_cpu !== 32'h84 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_issue: got addr=%h valid=%b expected addr=84 valid=0", addr_cpu, rsp_valid);
        end
        tick();                       // WAIT
        we_seen   = we_seen | (we_cpu != 4'h0);
        n_checks++;
        if (addr_cpu !== 32'h84 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_wait: got addr=%h valid=%b expected addr=84 valid=0", addr_cpu, rsp_valid);
        end
        tick();                       // RESP
        we_seen   = we_seen | (we_cpu != 4'h0);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3 || rsp_write !== 1'b0) begin
            n_fail++;
            $display("FAIL read_resp: got valid=%b rdata=%h write=%b expected valid=1 rdata=3 write=0",
                     rsp_valid, rsp_rdata, rsp_write);
        end
        n_checks++;
        if (we_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL read_we_zero: got we_seen=%b expected 0", we_seen);
        end
        tick();
    endtask

    task automatic test_fill_drain();
        int acc;
        int got;
        logic taken;
        acc       = 0;
        got       = 0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_be    = 4'h0;
        for (int c = 0; c < 10; c++) begin
            cmd_addr = 32'h100 + 32'(acc * 4);
            taken    = cmd_ready;
            tick();
            if (taken) acc++;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (acc !== 5 || cmd_ready !== 1'b0 || cmd_count !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_full: got accepted=%0d ready=%b count=%0d expected accepted=5 ready=0 count=4",
                     acc, cmd_ready, cmd_count);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (rsp_valid) begin
                n_checks++;
                if (rsp_rdata !== 32'h1100 + 32'(got * 4)) begin
                    n_fail++;
                    $display("FAIL drain_order[%0d]: got rdata=%h expected %h", got, rsp_rdata, 32'h1100 + 32'(got * 4));
                end
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 5 || cmd_count !== 3'd0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_done: got responses=%0d count=%0d ready=%b expected responses=5 count=0 ready=1",
                     got, cmd_count, cmd_ready);
        end
    endtask

    task automatic test_back_to_back_stall();
        int waited;
        logic found;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h90;
        cmd_wdata = 32'h55;
        cmd_be    = 4'h3;
        tick();
        cmd_write = 1'b0;
        cmd_addr  = 32'h94;
        cmd_wdata = 32'h0;
        tick();                       // write in ISSUE, read queued
        cmd_valid = 1'b0;
        n_checks++;
        if (we_cpu !== 4'h3 || addr_cpu !== 32'h90 || wdata_cpu !== 32'h55) begin
            n_fail++;
            $display("FAIL stall_issue: got we=%h addr=%h wdata=%h expected we=3 addr=90 wdata=55", we_cpu, addr_cpu, wdata_cpu);
        end
        found = 1'b0;
        for (waited = 0; waited < 10 && !found; waited++) begin
            tick();
            found = rsp_valid;
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resp_timeout: got rsp_valid=%b after %0d cycles expected 1", rsp_valid, waited);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0 ||
                addr_cpu !== 32'h90 || we_cpu !== 4'h0 || cmd_count !== 3'd1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%b write=%b rdata=%h addr=%h we=%h count=%0d expected 1 1 0 90 0 1",
                         k, rsp_valid, rsp_write, rsp_rdata, addr_cpu, we_cpu, cmd_count);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();                       // handshake edge -> read ISSUE
        n_checks++;
        if (rsp_valid !== 1'b0 || addr_cpu !== 32'h94 || we_cpu !== 4'h0 || cmd_count !== 3'd0) begin
            n_fail++;
            $display("FAIL stall_next_issue: got valid=%b addr=%h we=%h count=%0d expected valid=0 addr=94 we=0 count=0",
                     rsp_valid, addr_cpu, we_cpu, cmd_count);
        end
        tick();                       // WAIT
        tick();                       // RESP
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h1094) begin
            n_fail++;
            $display("FAIL stall_read_resp: got valid=%b write=%b rdata=%h expected valid=1 write=0 rdata=1094",
                     rsp_valid, rsp_write, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h88;
        cmd_wdata = 32'h0;
        cmd_be    = 4'h0;
        tick();
        cmd_write = 1'b1;
        cmd_addr  = 32'h200;
        cmd_wdata = 32'h77;
        cmd_be    = 4'hF;
        tick();                       // read ISSUE, write queued
        cmd_valid = 1'b0;
        tick();                       // WAIT
        n_checks++;
        if (addr_cpu !== 32'h88 || we_cpu !== 4'h0 || cmd_count !== 3'd1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_wait: got addr=%h we=%h count=%0d valid=%b expected addr=88 we=0 count=1 valid=0",
                     addr_cpu, we_cpu, cmd_count, rsp_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_rdata, rsp_write, addr_cpu, wdata_cpu, we_cpu, cmd_count} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: got valid=%b rdata=%h write=%b addr=%h wdata=%h we=%h count=%0d expected all zero",
                     rsp_valid, rsp_rdata, rsp_write, addr_cpu, wdata_cpu, we_cpu, cmd_count);
        end
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || cmd_count !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_release: got ready=%b count=%0d expected ready=1 count=0", cmd_ready, cmd_count);
        end
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen = seen | rsp_valid | (we_cpu != 4'h0);
            tick();
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_resp: got activity=%b expected 0", seen);
        end
    endtask

    task automatic test_latency();
        int lat0;
        int lat3;
        logic [31:0] d0;
        logic [31:0] d3;
        lat0 = -1;
        lat3 = -1;
        d0   = '0;
        d3   = '0;
        do_reset();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h8C;
        cmd_wdata = 32'h0;
        cmd_be    = 4'h0;
        tick();
        cmd_valid = 1'b0;
        tick();                       // ISSUE in both builds
        n_checks++;
        if (z_addr_cpu !== 32'h8C || t_addr_cpu !== 32'h8C || z_rsp_valid !== 1'b0 || t_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_issue: got addr0=%h addr3=%h v0=%b v3=%b expected 8c 8c 0 0",
                     z_addr_cpu, t_addr_cpu, z_rsp_valid, t_rsp_valid);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (z_rsp_valid && lat0 < 0) begin lat0 = k; d0 = z_rsp_rdata; end
            if (t_rsp_valid && lat3 < 0) begin lat3 = k; d3 = t_rsp_rdata; end
        end
        n_checks++;
        if (lat0 !== 1 || d0 !== 32'h9) begin
            n_fail++;
            $display("FAIL lat0_resp: got latency=%0d rdata=%h expected latency=1 rdata=9", lat0, d0);
        end
        n_checks++;
        if (lat3 !== 4 || d3 !== 32'h9) begin
            n_fail++;
            $display("FAIL lat3_resp: got latency=%0d rdata=%h expected latency=4 rdata=9", lat3, d3);
        end
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_fill_drain();
        test_back_to_back_stall();
        test_reset_mid();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
